// File: rtl/settings_pkg.sv
// rtl/settings_pkg.sv - shared types, widths and mask helpers for the AMM burst engine.
package settings_pkg;

  localparam int AMM_DATA_W    = 128;
  localparam int AMM_ADDR_W    = 32;
  localparam int CNT_W         = 16;
  localparam int BYTE_PER_WORD = AMM_DATA_W / 8;
  localparam int BYTE_ADDR_W   = $clog2(BYTE_PER_WORD);

  typedef enum logic {BYTE = 1'b0, WORD = 1'b1} addr_type_e;
  typedef enum logic {FIX = 1'b0, RND = 1'b1} data_mode_type;

  typedef struct packed {
    logic [AMM_ADDR_W-1:0]    word_addr;
    logic [CNT_W-1:0]         len_m1;
    logic [BYTE_PER_WORD-1:0] start_mask;
    logic [BYTE_PER_WORD-1:0] end_mask;
    data_mode_type            ptrn_mode;
    logic [7:0]               ptrn_byte;
  } pkt_struct_type;

  function automatic logic [BYTE_PER_WORD-1:0] start_mask_f(input logic [BYTE_ADDR_W-1:0] off);
    logic [BYTE_PER_WORD-1:0] m;
    for (int i = 0; i < BYTE_PER_WORD; i++) m[i] = (i >= int'(off));
    return m;
  endfunction

  function automatic logic [BYTE_PER_WORD-1:0] end_mask_f(input logic [BYTE_ADDR_W-1:0] off);
    logic [BYTE_PER_WORD-1:0] m;
    for (int i = 0; i < BYTE_PER_WORD; i++) m[i] = (i <= int'(off));
    return m;
  endfunction

endpackage

// File: rtl/data_ptrn_gen.sv
// rtl/data_ptrn_gen.sv - pattern byte source: fixed byte or free-running 8-bit LFSR.
// The LFSR only moves on accepted RND beats and is never cleared between commands.
module data_ptrn_gen
  import settings_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  data_mode_type mode_i,
  input  logic [7:0]    fix_i,
  input  logic          adv_i,
  output logic [7:0]    byte_o
);

  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    // x^8+x^6+x^5+x^4+1, left shift
    if (adv_i && mode_i == RND)
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lfsr_q <= 8'hFF;
    else       lfsr_q <= lfsr_d;
  end

  assign byte_o = (mode_i == RND) ? lfsr_q : fix_i;

endmodule

// File: rtl/amm_burst_engine.sv
// rtl/amm_burst_engine.sv - splits checker commands into Avalon-MM bursts with read credit limiting.
// Optional TRANS_STAT_EN adds saturating write/read word counters.
module amm_burst_engine
  import settings_pkg::*;
#(
  parameter int         AMM_BURST_W  = 11,
  parameter addr_type_e ADDR_TYPE    = BYTE,
  parameter int         MAX_BURST    = 64,
  parameter int         MAX_RD_WORDS = 256
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic                     cmd_type_i,
  input  logic [AMM_ADDR_W-1:0]    cmd_word_addr_i,
  input  logic [CNT_W-1:0]         cmd_word_cnt_i,
  input  logic [BYTE_ADDR_W-1:0]   cmd_start_off_i,
  input  logic [BYTE_ADDR_W-1:0]   cmd_end_off_i,
  input  logic                     ptrn_mode_i,
  input  logic [7:0]               fix_ptrn_i,
  input  logic                     abort_i,
  output logic                     busy_o,
`ifdef TRANS_STAT_EN
  output logic [31:0]              stat_wr_words_o,
  output logic [31:0]              stat_rd_words_o,
`endif
  output logic [CNT_W-1:0]         rd_pending_o,
  output logic                     rd_unexp_o,
  output logic                     cmp_valid_o,
  output pkt_struct_type           cmp_pkt_o,
  output logic [AMM_ADDR_W-1:0]    address_o,
  output logic                     read_o,
  output logic                     write_o,
  output logic [AMM_DATA_W-1:0]    writedata_o,
  output logic [AMM_BURST_W-1:0]   burstcount_o,
  output logic [BYTE_PER_WORD-1:0] byteenable_o,
  input  logic                     waitrequest_i,
  input  logic                     readdatavalid_i
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WR, S_RD_WAIT, S_RD} state_e;

  localparam logic [CNT_W:0]   MAX_BURST_C = (CNT_W+1)'(MAX_BURST);
  localparam logic [CNT_W+1:0] MAX_RD_C    = (CNT_W+2)'(MAX_RD_WORDS);

  state_e                   state_q, state_d;
  logic                     ready_q, ready_d;
  logic                     type_q, type_d;
  logic [AMM_ADDR_W-1:0]    addr_q, addr_d;
  logic [CNT_W:0]           rem_q, rem_d;
  logic [BYTE_ADDR_W-1:0]   soff_q, soff_d, eoff_q, eoff_d;
  data_mode_type            mode_q, mode_d;
  logic [7:0]               fix_q, fix_d;
  logic                     abort_q, abort_d;
  logic                     first_burst_q, first_burst_d;
  logic [AMM_BURST_W-1:0]   len_q, len_d, beat_q, beat_d, bc_q, bc_d;
  logic                     write_q, write_d, read_q, read_d;
  logic [AMM_ADDR_W-1:0]    address_q, address_d;
  pkt_struct_type           pkt_q, pkt_d;
  logic [CNT_W-1:0]         pend_q, pend_d;
  logic                     unexp_q, unexp_d;

  logic [CNT_W:0]           len_calc, len_ext;
  logic [BYTE_PER_WORD-1:0] smask, emask, be_wr;
  logic [7:0]               ptrn_byte;
  logic                     wr_acc, rd_acc, last_beat, end_burst, credit_load, credit_wait, rd_dec;

  assign wr_acc    = write_q && !waitrequest_i;
  assign rd_acc    = read_q && !waitrequest_i;
  assign len_calc  = (rem_q > MAX_BURST_C) ? MAX_BURST_C : rem_q;
  assign len_ext   = (CNT_W+1)'(len_q);
  assign last_beat = (beat_q == len_q - AMM_BURST_W'(1));
  assign smask     = start_mask_f(soff_q);
  assign emask     = end_mask_f(eoff_q);
  assign rd_dec    = readdatavalid_i && (pend_q != '0);

  assign credit_load = ({2'b00, pend_q} + (CNT_W+2)'(len_calc)) <= MAX_RD_C;
  assign credit_wait = ({2'b00, pend_q} + (CNT_W+2)'(len_q)) <= MAX_RD_C;

  data_ptrn_gen u_ptrn (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .mode_i (mode_q),
    .fix_i  (fix_q),
    .adv_i  (wr_acc),
    .byte_o (ptrn_byte)
  );

  always_comb begin
    state_d       = state_q;
    ready_d       = ready_q;
    type_d        = type_q;
    addr_d        = addr_q;
    rem_d         = rem_q;
    soff_d        = soff_q;
    eoff_d        = eoff_q;
    mode_d        = mode_q;
    fix_d         = fix_q;
    abort_d       = abort_q;
    first_burst_d = first_burst_q;
    len_d         = len_q;
    beat_d        = beat_q;
    bc_d          = bc_q;
    write_d       = write_q;
    read_d        = read_q;
    address_d     = address_q;
    pkt_d         = pkt_q;
    end_burst     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i && ready_q) begin
          type_d        = cmd_type_i;
          addr_d        = cmd_word_addr_i;
          rem_d         = (CNT_W+1)'(cmd_word_cnt_i) + 1'b1;
          soff_d        = cmd_start_off_i;
          eoff_d        = cmd_end_off_i;
          mode_d        = data_mode_type'(ptrn_mode_i);
          fix_d         = fix_ptrn_i;
          abort_d       = 1'b0;
          first_burst_d = 1'b1;
          ready_d       = 1'b0;
          state_d       = S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort_q || abort_i) begin
          ready_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          len_d     = AMM_BURST_W'(len_calc);
          bc_d      = AMM_BURST_W'(len_calc);
          beat_d    = '0;
          address_d = (ADDR_TYPE == BYTE) ? (addr_q << BYTE_ADDR_W) : addr_q;
          if (!type_q) begin
            pkt_d.word_addr  = addr_q;
            pkt_d.len_m1     = CNT_W'(len_calc - 1'b1);
            pkt_d.start_mask = (ADDR_TYPE == BYTE && first_burst_q) ? smask : '1;
            pkt_d.end_mask   = (ADDR_TYPE == BYTE && rem_q == len_calc) ? emask : '1;
            pkt_d.ptrn_mode  = mode_q;
            pkt_d.ptrn_byte  = ptrn_byte;
            write_d          = 1'b1;
            state_d          = S_WR;
          end else if (credit_load) begin
            read_d  = 1'b1;
            state_d = S_RD;
          end else begin
            state_d = S_RD_WAIT;
          end
        end
      end
      S_WR: begin
        if (abort_i) abort_d = 1'b1;
        if (wr_acc) begin
          beat_d = beat_q + AMM_BURST_W'(1);
          if (last_beat) begin
            write_d   = 1'b0;
            end_burst = 1'b1;
          end
        end
      end
      S_RD_WAIT: begin
        if (abort_q || abort_i) begin
          ready_d = 1'b1;
          state_d = S_IDLE;
        end else if (credit_wait) begin
          read_d  = 1'b1;
          state_d = S_RD;
        end
      end
      S_RD: begin
        if (abort_i) abort_d = 1'b1;
        if (rd_acc) begin
          read_d    = 1'b0;
          end_burst = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Burst boundary: the only point where an abort may take effect.
    if (end_burst) begin
      rem_d         = rem_q - len_ext;
      addr_d        = addr_q + AMM_ADDR_W'(len_q);
      first_burst_d = 1'b0;
      if (rem_d == '0 || abort_q || abort_i) begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end else begin
        state_d = S_LOAD;
      end
    end
  end

  always_comb begin
    be_wr = '1;
    if (ADDR_TYPE == BYTE) begin
      if (first_burst_q && beat_q == '0) be_wr = be_wr & smask;
      if (rem_q == len_ext && last_beat) be_wr = be_wr & emask;
    end
  end

  always_comb begin
    pend_d = pend_q;
    if (rd_acc) pend_d = pend_d + CNT_W'(len_q);
    if (rd_dec) pend_d = pend_d - CNT_W'(1);
    unexp_d = unexp_q | (readdatavalid_i && pend_q == '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      ready_q       <= 1'b1;
      type_q        <= 1'b0;
      addr_q        <= '0;
      rem_q         <= '0;
      soff_q        <= '0;
      eoff_q        <= '0;
      mode_q        <= FIX;
      fix_q         <= '0;
      abort_q       <= 1'b0;
      first_burst_q <= 1'b0;
      len_q         <= '0;
      beat_q        <= '0;
      bc_q          <= '0;
      write_q       <= 1'b0;
      read_q        <= 1'b0;
      address_q     <= '0;
      pkt_q         <= '0;
      pend_q        <= '0;
      unexp_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      ready_q       <= ready_d;
      type_q        <= type_d;
      addr_q        <= addr_d;
      rem_q         <= rem_d;
      soff_q        <= soff_d;
      eoff_q        <= eoff_d;
      mode_q        <= mode_d;
      fix_q         <= fix_d;
      abort_q       <= abort_d;
      first_burst_q <= first_burst_d;
      len_q         <= len_d;
      beat_q        <= beat_d;
      bc_q          <= bc_d;
      write_q       <= write_d;
      read_q        <= read_d;
      address_q     <= address_d;
      pkt_q         <= pkt_d;
      pend_q        <= pend_d;
      unexp_q       <= unexp_d;
    end
  end

`ifdef TRANS_STAT_EN
  logic [31:0] stat_wr_q, stat_wr_d, stat_rd_q, stat_rd_d;

  always_comb begin
    stat_wr_d = stat_wr_q;
    stat_rd_d = stat_rd_q;
    if (wr_acc && stat_wr_q != '1) stat_wr_d = stat_wr_q + 32'd1;
    if (rd_dec && stat_rd_q != '1) stat_rd_d = stat_rd_q + 32'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_wr_q <= '0;
      stat_rd_q <= '0;
    end else begin
      stat_wr_q <= stat_wr_d;
      stat_rd_q <= stat_rd_d;
    end
  end

  assign stat_wr_words_o = stat_wr_q;
  assign stat_rd_words_o = stat_rd_q;
`endif

  assign cmd_ready_o  = ready_q;
  assign busy_o       = (state_q != S_IDLE);
  assign rd_pending_o = pend_q;
  assign rd_unexp_o   = unexp_q;
  assign cmp_valid_o  = wr_acc && (beat_q == '0);
  assign cmp_pkt_o    = pkt_q;
  assign address_o    = address_q;
  assign read_o       = read_q;
  assign write_o      = write_q;
  assign burstcount_o = bc_q;
  assign writedata_o  = write_q ? {BYTE_PER_WORD{ptrn_byte}} : '0;
  assign byteenable_o = write_q ? be_wr : (read_q ? '1 : '0);

endmodule
